// File: rtl/pam_demodu.sv
// PAM demodulator: slices synchronised AD samples to PAM symbols, packs them MSB-first
// into DATA_WIDTH words and streams them out as an AXI-Stream master with frame tlast.
module pam_demodu #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned PAM_ORDER     = 4,
  parameter int unsigned AD_CVER_WIDTH = 12,
  parameter int unsigned LENGTH_DATA   = 1024
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      syn_demodu_valid,
  input  logic [AD_CVER_WIDTH-1:0]  syn_demodu_data,
  output logic                      syn_demodu_ready,
  output logic [DATA_WIDTH-1:0]     S_AXIS_tdata,
  output logic [DATA_WIDTH/8-1:0]   S_AXIS_tkeep,
  output logic                      S_AXIS_tlast,
  output logic                      S_AXIS_tvalid,
  input  logic                      S_AXIS_tready,
  output logic [15:0]               frame_cnt
);

  localparam int unsigned Bits   = $clog2(PAM_ORDER);
  localparam int unsigned Spw    = DATA_WIDTH / Bits;
  localparam int unsigned Wpf    = LENGTH_DATA / Spw;
  localparam int unsigned ShW    = (Spw > 1) ? $clog2(Spw) : 1;
  localparam int unsigned WcW    = (Wpf > 1) ? $clog2(Wpf) : 1;
  localparam int unsigned ShBits = DATA_WIDTH - Bits;
  localparam logic [ShW-1:0] ShLast = ShW'(Spw - 1);
  localparam logic [WcW-1:0] WcLast = WcW'(Wpf - 1);

  logic [Bits-1:0]       sym;
  logic                  accept;
  logic                  out_fire;
  logic                  unused_low_bits;

  // The shift register only needs to hold the first Spw-1 symbols of a word.
  logic [ShBits-1:0]     sh_q, sh_d;
  logic [ShW-1:0]        sh_cnt_q, sh_cnt_d;
  logic [WcW-1:0]        wrd_cnt_q, wrd_cnt_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tlast_q, tlast_d;
  logic                  tvalid_q, tvalid_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;

  // Uniform thresholds in offset binary reduce to the top BITS of the sample.
  assign sym             = syn_demodu_data[AD_CVER_WIDTH-1 -: Bits];
  assign unused_low_bits = ^syn_demodu_data[AD_CVER_WIDTH-Bits-1:0];

  assign syn_demodu_ready = !tvalid_q || S_AXIS_tready;
  assign accept           = syn_demodu_valid && syn_demodu_ready;
  assign out_fire         = tvalid_q && S_AXIS_tready;

  always_comb begin
    sh_d        = sh_q;
    sh_cnt_d    = sh_cnt_q;
    wrd_cnt_d   = wrd_cnt_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;
    tvalid_d    = tvalid_q;
    frame_cnt_d = frame_cnt_q;

    if (out_fire) begin
      tvalid_d = 1'b0;
      if (tlast_q) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end

    if (accept) begin
      if (sh_cnt_q == ShLast) begin
        tdata_d  = {sh_q, sym};
        tvalid_d = 1'b1;
        tlast_d  = (wrd_cnt_q == WcLast);
        sh_cnt_d = '0;
        if (wrd_cnt_q == WcLast) begin
          wrd_cnt_d = '0;
        end else begin
          wrd_cnt_d = wrd_cnt_q + WcW'(1);
        end
      end else begin
        sh_d     = ShBits'({sh_q, sym});
        sh_cnt_d = sh_cnt_q + ShW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sh_q        <= '0;
      sh_cnt_q    <= '0;
      wrd_cnt_q   <= '0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      sh_q        <= sh_d;
      sh_cnt_q    <= sh_cnt_d;
      wrd_cnt_q   <= wrd_cnt_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      tvalid_q    <= tvalid_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign S_AXIS_tdata  = tdata_q;
  assign S_AXIS_tkeep  = '1;
  assign S_AXIS_tlast  = tlast_q;
  assign S_AXIS_tvalid = tvalid_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_pam_demodu.sv
// Bench for pam_demodu: directed vectors plus an in-order sample scoreboard whose expected
// words are built from the sample list, independent of handshake timing.
module tb_pam_demodu;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        valid = 1'b0;
  logic [11:0] data = '0;
  logic        ready;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready = 1'b0;
  logic [15:0] frame_cnt;

  pam_demodu #(
    .DATA_WIDTH   (32),
    .PAM_ORDER    (4),
    .AD_CVER_WIDTH(12),
    .LENGTH_DATA  (1024)
  ) dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .syn_demodu_valid(valid),
    .syn_demodu_data (data),
    .syn_demodu_ready(ready),
    .S_AXIS_tdata    (tdata),
    .S_AXIS_tkeep    (tkeep),
    .S_AXIS_tlast    (tlast),
    .S_AXIS_tvalid   (tvalid),
    .S_AXIS_tready   (tready),
    .frame_cnt       (frame_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [11:0] samp[$];
  int          sidx, words_seen, tlast_seen, ready_low, cyc;
  int          vprob, rprob, st_start, st_len;
  bit          hold_pend;
  logic [31:0] hold_data;
  logic        hold_last;
  logic [11:0] t2v[4] = '{12'h000, 12'h7FF, 12'h800, 12'hFFF};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input int w);
    logic [31:0] r = '0;
    for (int j = 0; j < 16; j++) begin
      r = {r[29:0], samp[16*w+j][11:10]};
    end
    return r;
  endfunction

  task automatic clear_bench();
    sidx       = 0;
    words_seen = 0;
    tlast_seen = 0;
    ready_low  = 0;
    cyc        = 0;
    hold_pend  = 1'b0;
  endtask

  task automatic fill(input int n);
    samp.delete();
    for (int i = 0; i < n; i++) samp.push_back(12'($urandom_range(0, 4095)));
  endtask

  // One clock: observe at negedge (handshakes happen at the next posedge), then drive.
  task automatic cycle();
    @(negedge clk);
    if (hold_pend) begin
      check("hold_tvalid", tvalid, 1'b1);
      check("hold_tdata", tdata, hold_data);
      check("hold_tlast", tlast, hold_last);
    end
    check("ready_rule", ready, !tvalid || tready);
    if (tvalid && tready) begin
      if (words_seen >= samp.size() / 16) begin
        check("extra_word", 1'b1, 1'b0);
      end else begin
        check("word", tdata, exp_word(words_seen));
        check("tlast", tlast, (words_seen % 64) == 63);
      end
      if (tlast) tlast_seen++;
      words_seen++;
    end
    hold_pend = tvalid && !tready;
    hold_data = tdata;
    hold_last = tlast;
    if (valid) begin
      if (ready) sidx++;
      else ready_low++;
    end
    @(posedge clk);
    #1;
    if (cyc >= st_start && cyc < st_start + st_len) tready = 1'b0;
    else tready = ($urandom_range(0, 99) < rprob);
    if (sidx < samp.size() && $urandom_range(0, 99) < vprob) begin
      valid = 1'b1;
      data  = samp[sidx];
    end else begin
      valid = 1'b0;
      data  = 12'($urandom_range(0, 4095));
    end
    cyc++;
  endtask

  task automatic run(input int budget);
    int  n = samp.size();
    bit  done;
    while (!(sidx == n && words_seen == n / 16) && cyc < budget) cycle();
    done  = (sidx == n) && (words_seen == n / 16);
    valid = 1'b0;
    check("run_done", done, 1'b1);
  endtask

  task automatic apply_reset(input bit chk);
    @(posedge clk);
    #3;
    arst_n = 1'b0;
    valid  = 1'b0;
    #1;
    if (chk) begin
      check("rst_tvalid", tvalid, 1'b0);
      check("rst_tlast", tlast, 1'b0);
      check("rst_frame_cnt", frame_cnt, 16'd0);
      check("rst_ready", ready, 1'b1);
      check("rst_tkeep", tkeep, 4'hF);
    end
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    clear_bench();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    st_start = -1;
    st_len   = 0;
    clear_bench();

    // Power-on reset values
    #12;
    check("por_tvalid", tvalid, 1'b0);
    check("por_tlast", tlast, 1'b0);
    check("por_frame_cnt", frame_cnt, 16'd0);
    check("por_tdata", tdata, 32'd0);
    check("por_tkeep", tkeep, 4'hF);
    @(negedge clk);
    arst_n = 1'b1;

    // T2: directed slicer thresholds and MSB-first packing, one-cycle latency
    tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      valid = 1'b1;
      data  = t2v[i % 4];
      @(negedge clk);
      check("t2_ready", ready, 1'b1);
      check("t2_tvalid_early", tvalid, 1'b0);
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
    data  = 12'hFFF;
    @(negedge clk);
    check("t2_tvalid", tvalid, 1'b1);
    check("t2_tdata", tdata, 32'h1B1B_1B1B);
    check("t2_tlast", tlast, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t2_tvalid_clear", tvalid, 1'b0);

    // T3: one full frame back-to-back
    apply_reset(1'b0);
    vprob = 100; rprob = 100; st_start = -1; st_len = 0;
    fill(1024);
    run(2000);
    check("t3_words", words_seen, 64);
    check("t3_tlast_cnt", tlast_seen, 1);
    check("t3_ready_idle", ready_low, 0);
    check("t3_frame_cnt", frame_cnt, 16'd1);

    // T4: 20-cycle tready stall with valid held high
    apply_reset(1'b0);
    vprob = 100; rprob = 100; st_start = 10; st_len = 20;
    fill(128);
    run(1000);
    check("t4_words", words_seen, 8);
    check("t4_ready_dropped", ready_low > 0, 1'b1);
    check("t4_frame_cnt", frame_cnt, 16'd0);

    // T5: three frames with random valid/tready
    apply_reset(1'b0);
    vprob = 50; rprob = 50; st_start = -1; st_len = 0;
    fill(3072);
    run(30000);
    check("t5_words", words_seen, 192);
    check("t5_tlast_cnt", tlast_seen, 3);
    check("t5_frame_cnt", frame_cnt, 16'd3);

    // T1: mid-frame reset with a word stuck in the output register
    clear_bench();
    vprob = 100; rprob = 100;
    fill(300);
    run(1000);
    tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      valid = 1'b1;
      data  = 12'($urandom_range(0, 4095));
    end
    @(negedge clk);
    check("t1_stall_ready", ready, 1'b0);
    check("t1_stall_tvalid", tvalid, 1'b1);
    check("t1_pre_frame_cnt", frame_cnt, 16'd3);
    apply_reset(1'b1);

    // T6: full frame after reset recovery; word 0 must start at the new symbol 0
    vprob = 100; rprob = 100; st_start = -1; st_len = 0;
    fill(1024);
    run(2000);
    check("t6_words", words_seen, 64);
    check("t6_tlast_cnt", tlast_seen, 1);
    check("t6_frame_cnt", frame_cnt, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
